timer_run_controller: RTL and testbench

//  Sequencing controller for the 2-digit BCD second counter: owns preset entry, start/pause/resume, completion detect and alarm.

---
 rtl/timer_run_controller.sv | 167 ++++++++++++++++
 tb/tb_timer_run_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timer_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer_run_controller
// Description : Preset/start/pause/resume sequencer for a 2-digit BCD seconds
//               counter with a self-generated 1 s tick and timed alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_run_controller #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       direction,
    output logic [3:0] bcd_units,
    output logic [3:0] bcd_tens,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] C_ALARM_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state,     w_state_nx;
    logic [7:0]    r_preset,    w_preset_nx;    // {tens, units}
    logic [7:0]    r_count,     w_count_nx;     // {tens, units}
    logic [TW-1:0] r_tick_cnt,  w_tick_cnt_nx;
    logic [AW-1:0] r_alarm_cnt, w_alarm_cnt_nx;
    logic          r_dir,       w_dir_nx;
    logic          w_tick;
    logic [7:0]    w_step;
    logic          w_complete;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign w_tick     = ((r_state == S_RUN) || (r_state == S_DONE)) && (r_tick_cnt == C_TICK_LAST);
    assign w_step     = r_dir ? bcd_inc(r_count) : bcd_dec(r_count);
    assign w_complete = r_dir ? (w_step == r_preset) : (w_step == 8'h00);

    always_comb begin
        w_state_nx     = r_state;
        w_preset_nx    = r_preset;
        w_count_nx     = r_count;
        w_dir_nx       = r_dir;
        w_alarm_cnt_nx = r_alarm_cnt;
        w_tick_cnt_nx  = r_tick_cnt;
        if ((r_state == S_RUN) || (r_state == S_DONE)) begin
            w_tick_cnt_nx = w_tick ? '0 : r_tick_cnt + 1'b1;
        end

        if (btn_clear) begin
            w_state_nx     = S_IDLE;
            w_count_nx     = 8'h00;
            w_tick_cnt_nx  = '0;
            w_alarm_cnt_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (btn_start) begin
                        if (r_preset != 8'h00) begin
                            w_state_nx    = S_RUN;
                            w_dir_nx      = direction;
                            w_count_nx    = direction ? 8'h00 : r_preset;
                            w_tick_cnt_nx = '0;
                        end
                    end else if (btn_set) begin
                        w_preset_nx = bcd_inc(r_preset);
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_count_nx = w_step;
                        if (w_complete) begin
                            w_state_nx     = S_DONE;
                            w_tick_cnt_nx  = '0;
                            w_alarm_cnt_nx = '0;
                        end
                    end
                    // A completing tick outranks a pause request on the same edge
                    if (btn_start && !(w_tick && w_complete)) begin
                        w_state_nx = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) begin
                        w_state_nx = S_RUN;
                    end
                end
                S_DONE: begin
                    if ((w_tick && (r_alarm_cnt == C_ALARM_LAST)) || btn_start) begin
                        w_state_nx    = S_IDLE;
                        w_count_nx    = 8'h00;
                        w_tick_cnt_nx = '0;
                    end else if (w_tick) begin
                        w_alarm_cnt_nx = r_alarm_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_preset    <= 8'h00;
            r_count     <= 8'h00;
            r_tick_cnt  <= '0;
            r_alarm_cnt <= '0;
            r_dir       <= 1'b0;
            running     <= 1'b0;
            alarm       <= 1'b0;
            bcd_tens    <= 4'd0;
            bcd_units   <= 4'd0;
        end else begin
            r_state     <= w_state_nx;
            r_preset    <= w_preset_nx;
            r_count     <= w_count_nx;
            r_tick_cnt  <= w_tick_cnt_nx;
            r_alarm_cnt <= w_alarm_cnt_nx;
            r_dir       <= w_dir_nx;
            running     <= (w_state_nx == S_RUN);
            alarm       <= (w_state_nx == S_DONE);
            {bcd_tens, bcd_units} <= (w_state_nx == S_IDLE) ? w_preset_nx : w_count_nx;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_run_controller
// Description : Scoreboard bench for timer_run_controller against an
//               integer-arithmetic reference model of the front-panel timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_run_controller;

    localparam int TD = 3;
    localparam int AT = 2;

    logic       clk = 1'b0;
    logic       reset, btn_set, btn_start, btn_clear, direction;
    logic [3:0] bcd_units, bcd_tens;
    logic [1:0] state;
    logic       running, alarm;

    timer_run_controller #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_set   (btn_set),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .direction (direction),
        .bcd_units (bcd_units),
        .bcd_tens  (bcd_tens),
        .state     (state),
        .running   (running),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, 0=IDLE 1=RUN 2=PAUSE 3=DONE
    int  m_st = 0, m_preset = 0, m_count = 0, m_tick = 0, m_acnt = 0;
    bit  m_dir = 1'b0;
    logic [11:0] exp_q[$];
    int  checks = 0, errors = 0;
    bit  dir_now = 1'b0;

    function automatic logic [11:0] model_outputs();
        int disp;
        disp = (m_st == 0) ? m_preset : m_count;
        return {2'(m_st), 4'(disp / 10), 4'(disp % 10), (m_st == 1), (m_st == 3)};
    endfunction

    task automatic model_step(input bit rs, input bit set, input bit st, input bit cl, input bit dir);
        bit tk;
        if (rs) begin
            m_st = 0; m_preset = 0; m_count = 0; m_tick = 0; m_acnt = 0; m_dir = 1'b0;
        end else if (cl) begin
            m_st = 0; m_count = 0; m_tick = 0; m_acnt = 0;
        end else begin
            case (m_st)
                0: begin
                    if (st) begin
                        if (m_preset != 0) begin
                            m_st = 1; m_dir = dir; m_tick = 0;
                            m_count = dir ? 0 : m_preset;
                        end
                    end else if (set) begin
                        m_preset = (m_preset + 1) % 100;
                    end
                end
                1: begin
                    tk = (m_tick == TD - 1);
                    m_tick = (m_tick + 1) % TD;
                    if (tk) begin
                        m_count = m_dir ? m_count + 1 : m_count - 1;
                        if ((m_dir && m_count == m_preset) || (!m_dir && m_count == 0)) begin
                            m_st = 3; m_tick = 0; m_acnt = 0;
                        end
                    end
                    if (m_st == 1 && st) m_st = 2;
                end
                2: begin
                    if (st) m_st = 1;
                end
                default: begin
                    tk = (m_tick == TD - 1);
                    m_tick = (m_tick + 1) % TD;
                    if (tk) begin
                        m_acnt++;
                        if (m_acnt == AT) begin
                            m_st = 0; m_count = 0; m_tick = 0;
                        end
                    end
                    if (m_st == 3 && st) begin
                        m_st = 0; m_count = 0; m_tick = 0;
                    end
                end
            endcase
        end
    endtask

    // Apply one cycle of inputs, predict the next-edge outputs, queue them
    task automatic drive(input bit rs, input bit set, input bit st, input bit cl);
        reset = rs; btn_set = set; btn_start = st; btn_clear = cl; direction = dir_now;
        model_step(rs, set, st, cl, dir_now);
        exp_q.push_back(model_outputs());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic presets(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: every edge the DUT presents a full output set
    initial begin
        logic [11:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                act_v = {state, bcd_tens, bcd_units, running, alarm};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs @%0t: actual st=%0d %0d/%0d run=%0b alm=%0b, required st=%0d %0d/%0d run=%0b alm=%0b",
                             $time, act_v[11:10], act_v[9:6], act_v[5:2], act_v[1], act_v[0],
                             exp_v[11:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        int r;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Preset 12 count-down to completion, alarm, auto-return
        presets(12);
        dir_now = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(50);

        // Preset wrap 99->00 and ignored start on zero preset
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        presets(100);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Preset 05 count-up with pause at 03 and resume
        presets(5);
        dir_now = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(9);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Preset 10 count-down across the borrow, direction toggled mid-run
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        presets(5);
        dir_now = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            dir_now = ~dir_now;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(7);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 19) == 0) dir_now = ~dir_now;
            drive(r < 2, (r >= 21 && r < 300), (r >= 7 && r < 21), (r >= 2 && r < 7));
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
